// File: rtl/udm_bus_slave.sv
// UDM debug-bus slave: GPO/GPI CSR banks, byte-writable test memory, error counter.
// Optional macro UDM_SLAVE_ERRCNT_EN enables the ERRCNT register and error counting.
module udm_bus_slave #(
    parameter int          OUT_CH        = 2,
    parameter int          IN_CH         = 2,
    parameter int          CH_WIDTH      = 16,
    parameter logic [CH_WIDTH-1:0] GPO_RST = '1,
    parameter logic [31:0] CSR_BASE      = 32'h0000_0000,
    parameter logic [31:0] MEM_BASE      = 32'h8000_0000,
    parameter int          MEM_WSIZE_POW = 10,
    parameter logic [31:0] ERR_RDATA     = 32'hDEAD_BEEF
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         bus_req_i,
    input  logic                         bus_we_i,
    input  logic [31:0]                  bus_addr_bi,
    input  logic [3:0]                   bus_be_bi,
    input  logic [31:0]                  bus_wdata_bi,
    output logic                         bus_ack_o,
    output logic                         bus_resp_o,
    output logic [31:0]                  bus_rdata_bo,
    output logic [OUT_CH*CH_WIDTH-1:0]   gpo_bo,
    input  logic [IN_CH*CH_WIDTH-1:0]    gpi_bi
);

`ifdef UDM_SLAVE_ERRCNT_EN
    localparam int NERR = 1;
`else
    localparam int NERR = 0;
`endif
    localparam int NCSR    = OUT_CH + IN_CH + NERR;
    localparam int ERR_IDX = OUT_CH + IN_CH;
    localparam int AW      = MEM_WSIZE_POW;

    localparam logic [1:0] K_CSR = 2'd0;
    localparam logic [1:0] K_MEM = 2'd1;
    localparam logic [1:0] K_ERR = 2'd2;

    logic [31:0]   csr_off;
    logic [31:0]   mem_off;
    logic          csr_hit;
    logic          mem_hit;
    logic [4:0]    csr_idx;
    logic [AW-1:0] mem_idx;
    logic [31:0]   be_mask;
    logic          acc_rd;
    logic          acc_wr;
    logic          unused;

    assign bus_ack_o = bus_req_i;
    assign acc_rd    = bus_req_i && !bus_we_i;
    assign acc_wr    = bus_req_i && bus_we_i;

    // Offsets wrap on subtraction, so one unsigned compare bounds each window
    assign csr_off = bus_addr_bi - CSR_BASE;
    assign mem_off = bus_addr_bi - MEM_BASE;
    assign csr_hit = (csr_off[31:2] < 30'(NCSR));
    assign mem_hit = !csr_hit && (mem_off[31:AW+2] == '0);
    assign csr_idx = csr_off[6:2];
    assign mem_idx = mem_off[AW+1:2];
    assign unused  = ^{csr_off[1:0], mem_off[1:0]};

    always_comb begin
        be_mask = '0;
        for (int b = 0; b < 4; b++)
            be_mask[8*b +: 8] = {8{bus_be_bi[b]}};
    end

    logic [CH_WIDTH-1:0] gpo_q [OUT_CH];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < OUT_CH; k++)
                gpo_q[k] <= GPO_RST;
        end else begin
            for (int k = 0; k < OUT_CH; k++)
                if (acc_wr && csr_hit && csr_idx == 5'(k))
                    gpo_q[k] <= (gpo_q[k] & ~be_mask[CH_WIDTH-1:0])
                              | (bus_wdata_bi[CH_WIDTH-1:0] & be_mask[CH_WIDTH-1:0]);
        end
    end

    for (genvar k = 0; k < OUT_CH; k++) begin : g_gpo
        assign gpo_bo[k*CH_WIDTH +: CH_WIDTH] = gpo_q[k];
    end

    logic [IN_CH*CH_WIDTH-1:0] gpi_m;
    logic [IN_CH*CH_WIDTH-1:0] gpi_s;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gpi_m <= '0;
            gpi_s <= '0;
        end else begin
            gpi_m <= gpi_bi;
            gpi_s <= gpi_m;
        end
    end

`ifdef UDM_SLAVE_ERRCNT_EN
    logic [15:0] errcnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            errcnt <= '0;
        else if (acc_wr && csr_hit && csr_idx == 5'(ERR_IDX))
            errcnt <= '0;
        else if (bus_req_i && !csr_hit && !mem_hit && errcnt != 16'hFFFF)
            errcnt <= errcnt + 16'd1;
    end
`endif

    logic          s1_vld;
    logic [1:0]    s1_kind;
    logic [4:0]    s1_csr_idx;
    logic [AW-1:0] s1_mem_idx;
    logic          s2_vld;
    logic [1:0]    s2_kind;
    logic [31:0]   s2_csr;
    logic [31:0]   mem_rd;
    logic [31:0]   csr_rd;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_vld     <= 1'b0;
            s1_kind    <= K_CSR;
            s1_csr_idx <= '0;
            s1_mem_idx <= '0;
        end else begin
            s1_vld     <= acc_rd;
            s1_kind    <= csr_hit ? K_CSR : (mem_hit ? K_MEM : K_ERR);
            s1_csr_idx <= csr_idx;
            s1_mem_idx <= mem_idx;
        end
    end

    logic [31:0] mem [2**AW];

    // Sampled one cycle after acceptance so a write just before the read is seen
    always_ff @(posedge clk_i) begin
        if (acc_wr && mem_hit)
            for (int b = 0; b < 4; b++)
                if (bus_be_bi[b])
                    mem[mem_idx][8*b +: 8] <= bus_wdata_bi[8*b +: 8];
        mem_rd <= mem[s1_mem_idx];
    end

    always_comb begin
        csr_rd = '0;
        for (int k = 0; k < OUT_CH; k++)
            if (s1_csr_idx == 5'(k))
                csr_rd = 32'(gpo_q[k]);
        for (int j = 0; j < IN_CH; j++)
            if (s1_csr_idx == 5'(OUT_CH + j))
                csr_rd = 32'(gpi_s[j*CH_WIDTH +: CH_WIDTH]);
`ifdef UDM_SLAVE_ERRCNT_EN
        if (s1_csr_idx == 5'(ERR_IDX))
            csr_rd = 32'(errcnt);
`endif
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_vld  <= 1'b0;
            s2_kind <= K_CSR;
            s2_csr  <= '0;
        end else begin
            s2_vld  <= s1_vld;
            s2_kind <= s1_kind;
            s2_csr  <= csr_rd;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bus_resp_o   <= 1'b0;
            bus_rdata_bo <= '0;
        end else begin
            bus_resp_o <= s2_vld;
            if (!s2_vld)
                bus_rdata_bo <= '0;
            else if (s2_kind == K_MEM)
                bus_rdata_bo <= mem_rd;
            else if (s2_kind == K_ERR)
                bus_rdata_bo <= ERR_RDATA;
            else
                bus_rdata_bo <= s2_csr;
        end
    end

endmodule

// File: tb/tb_udm_bus_slave.sv
// Randomized self-checking bench for udm_bus_slave against a word-level model.
module tb_udm_bus_slave;

    localparam logic [31:0] CSR_B = 32'h0000_0000;
    localparam logic [31:0] MEM_B = 32'h8000_0000;
    localparam logic [31:0] MEM_E = 32'h8000_1000;
    localparam logic [31:0] ERRD  = 32'hDEAD_BEEF;
`ifdef UDM_SLAVE_ERRCNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [3:0]  be = '0;
    logic [31:0] wdata = '0;
    logic        ack;
    logic        resp;
    logic [31:0] rdata;
    logic [31:0] gpo;
    logic [31:0] gpi = '0;

    always #5 clk = ~clk;

    udm_bus_slave dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .bus_req_i    (req),
        .bus_we_i     (we),
        .bus_addr_bi  (addr),
        .bus_be_bi    (be),
        .bus_wdata_bi (wdata),
        .bus_ack_o    (ack),
        .bus_resp_o   (resp),
        .bus_rdata_bo (rdata),
        .gpo_bo       (gpo),
        .gpi_bi       (gpi)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    logic [15:0] m_gpo [2];
    logic [31:0] m_mem [int];
    int          m_err;
    bit          pv [3];
    logic [31:0] pd [3];

    function automatic int csr_word(input logic [31:0] a);
        logic [31:0] off;
        off = a - CSR_B;
        if (off < 32'(4 * (4 + int'(ERR_EN))))
            return int'(off >> 2);
        return -1;
    endfunction

    function automatic bit in_mem(input logic [31:0] a);
        return a >= MEM_B && a < MEM_E;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int w;
        w = csr_word(a);
        if (w == 0 || w == 1)
            return {16'h0, m_gpo[w]};
        if (w == 2)
            return {16'h0, gpi[15:0]};
        if (w == 3)
            return {16'h0, gpi[31:16]};
        if (w == 4)
            return 32'(m_err);
        if (in_mem(a))
            return m_mem[int'((a - MEM_B) >> 2)];
        return ERRD;
    endfunction

    task automatic op(input bit r, input bit w, input logic [31:0] a,
                      input logic [3:0] b, input logic [31:0] d);
        int cw;
        int mi;
        @(negedge clk);
        req = r; we = w; addr = a; be = b; wdata = d;
        #1 chk("ack", ack, r);
        @(posedge clk);
        #1;
        pv[2] = pv[1]; pd[2] = pd[1];
        pv[1] = pv[0]; pd[1] = pd[0];
        pv[0] = r && !w;
        pd[0] = model_read(a);
        cw = csr_word(a);
        if (r) begin
            if (cw < 0 && !in_mem(a)) begin
                if (ERR_EN && m_err < 16'hFFFF) m_err++;
            end else if (w) begin
                if (cw == 0 || cw == 1) begin
                    for (int i = 0; i < 2; i++)
                        if (b[i]) m_gpo[cw][8*i +: 8] = d[8*i +: 8];
                end else if (cw == 4) begin
                    m_err = 0;
                end else if (cw < 0) begin
                    mi = int'((a - MEM_B) >> 2);
                    for (int i = 0; i < 4; i++)
                        if (b[i]) m_mem[mi][8*i +: 8] = d[8*i +: 8];
                end
            end
        end
        chk("resp", resp, pv[2]);
        chk(pv[2] ? "rdata" : "rdata_idle", rdata, pv[2] ? pd[2] : 32'h0);
        chk("gpo", gpo, {m_gpo[1], m_gpo[0]});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) op(0, 0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic model_reset();
        m_gpo[0] = 16'hFFFF;
        m_gpo[1] = 16'hFFFF;
        m_err = 0;
        for (int i = 0; i < 3; i++) begin
            pv[i] = 1'b0;
            pd[i] = '0;
        end
    endtask

    logic [31:0] ra;
    int          sel;

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gpo", gpo, 32'hFFFF_FFFF);
        chk("rst_resp", resp, 1'b0);
        chk("rst_rdata", rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        op(1, 0, CSR_B, 4'h0, 0);
        idle(3);

        for (int i = 0; i < 16; i++)
            op(1, 1, MEM_B + 32'(4 * i), 4'hF, $urandom);
        op(1, 1, MEM_B + 8, 4'h1, 32'h1234_5678);
        op(1, 0, MEM_B + 8, 4'h0, 0);
        idle(2);
        op(1, 1, CSR_B + 4, 4'h3, 32'h0000_A5A5);
        idle(1);

        gpi = 32'hBEEF_0001;
        idle(3);
        op(1, 0, CSR_B + 8, 4'h0, 0);
        op(1, 0, CSR_B + 12, 4'h0, 0);
        idle(2);

        repeat (3) op(1, 0, 32'h4000_0000, 4'h0, 0);
        op(1, 0, CSR_B + 16, 4'h0, 0);
        op(1, 1, CSR_B + 16, 4'hF, 32'h1);
        op(1, 0, CSR_B + 16, 4'h0, 0);
        idle(2);

        op(1, 1, MEM_B, 4'hF, 32'hCAFE_BABE);
        op(1, 0, MEM_B, 4'h0, 0);
        idle(2);

        for (int n = 0; n < 400; n++) begin
            if (n % 50 == 49) begin
                gpi = $urandom;
                idle(3);
            end
            sel = $urandom_range(0, 2);
            if (sel == 0)
                ra = CSR_B + 32'(4 * $urandom_range(0, 5));
            else if (sel == 1)
                ra = MEM_B + 32'(4 * $urandom_range(0, 15));
            else
                ra = 32'h4000_0000 | ($urandom & 32'h0FFF_FFFC);
            ra[1:0] = 2'($urandom);
            op($urandom_range(0, 9) < 8, 1'($urandom), ra, 4'($urandom), $urandom);
        end
        idle(3);

        op(1, 1, CSR_B, 4'hF, 32'h0000_1234);
        op(1, 0, MEM_B, 4'h0, 0);
        op(1, 0, CSR_B, 4'h0, 0);
        @(negedge clk);
        req = 1'b0;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("flush_resp", resp, 1'b0);
            chk("flush_gpo", gpo, 32'hFFFF_FFFF);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        idle(4);
        op(1, 0, CSR_B + 4, 4'h0, 0);
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
